// File: rtl/mem_wb_latch.sv
// mem_wb_latch -- MEM/WB pipeline register of the MIPS core.
//
// Captures the ALU result, the formatted load data and the write-back
// controls at the end of MEM and presents them to WB for one cycle.
// Load data is aligned and sign/zero extended (LB/LBU/LH/LHU/LW) before
// the register. Edge priority: reset > flush > stall > normal load.
//
// Optional feature, macro MEM_WB_HALT_EN:
//   adds i_halt / o_halt. o_halt is sticky until reset. While it is set
//   the register holds every field (flush is ignored, reset still applies).
//
// Ports:
//   i_clk           system clock, rising edge
//   i_reset         synchronous active-high reset
//   i_stall         hold all registered state
//   i_flush         load a bubble
//   i_valid         MEM stage holds a real instruction
//   i_data_alu      ALU result / store address
//   i_data_mem_raw  raw word read from data memory
//   i_addr_low      byte offset of the load address
//   i_mem_size      00 byte, 01 halfword, 10/11 word
//   i_mem_unsigned  1 = zero-extend, 0 = sign-extend
//   i_mem_to_reg    1 = write back load data
//   i_reg_write     instruction writes the register file
//   i_rd_addr       destination register
//   i_halt          (MEM_WB_HALT_EN) instruction in MEM is HALT
//   o_data_alu      registered ALU result
//   o_data_mem      registered formatted load data
//   o_wb_select     WB mux select, 1 = ALU, 0 = memory
//   o_reg_write     register-file write enable ($zero suppressed)
//   o_rd_addr       destination register
//   o_valid         WB stage holds a real instruction
//   o_halt          (MEM_WB_HALT_EN) sticky halt flag

module mem_wb_latch #(
  parameter int NB_INST = 32,
  parameter int NB_ADDR = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic               i_valid,
  input  logic [NB_INST-1:0] i_data_alu,
  input  logic [NB_INST-1:0] i_data_mem_raw,
  input  logic [1:0]         i_addr_low,
  input  logic [1:0]         i_mem_size,
  input  logic               i_mem_unsigned,
  input  logic               i_mem_to_reg,
  input  logic               i_reg_write,
  input  logic [NB_ADDR-1:0] i_rd_addr,
`ifdef MEM_WB_HALT_EN
  input  logic               i_halt,
  output logic               o_halt,
`endif
  output logic [NB_INST-1:0] o_data_alu,
  output logic [NB_INST-1:0] o_data_mem,
  output logic               o_wb_select,
  output logic               o_reg_write,
  output logic [NB_ADDR-1:0] o_rd_addr,
  output logic               o_valid
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic               ext_bit;
  logic [NB_INST-1:0] mem_fmt;
  logic               hold;

  // Little-endian lane selection; halfword ignores addr_low[0] (no trap).
  always_comb begin
    byte_sel = 8'h00;
    half_sel = 16'h0000;
    ext_bit  = 1'b0;
    mem_fmt  = i_data_mem_raw;
    case (i_addr_low)
      2'd0:    byte_sel = i_data_mem_raw[7:0];
      2'd1:    byte_sel = i_data_mem_raw[15:8];
      2'd2:    byte_sel = i_data_mem_raw[23:16];
      default: byte_sel = i_data_mem_raw[31:24];
    endcase
    half_sel = i_addr_low[1] ? i_data_mem_raw[31:16] : i_data_mem_raw[15:0];
    case (i_mem_size)
      SIZE_BYTE: begin
        ext_bit = ~i_mem_unsigned & byte_sel[7];
        mem_fmt = {{(NB_INST-8){ext_bit}}, byte_sel};
      end
      SIZE_HALF: begin
        ext_bit = ~i_mem_unsigned & half_sel[15];
        mem_fmt = {{(NB_INST-16){ext_bit}}, half_sel};
      end
      default: mem_fmt = i_data_mem_raw;
    endcase
  end

`ifdef MEM_WB_HALT_EN
  // Once halted the stage is frozen; only reset releases it.
  assign hold = o_halt;
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_data_alu  <= '0;
      o_data_mem  <= '0;
      o_wb_select <= 1'b1;
      o_reg_write <= 1'b0;
      o_rd_addr   <= '0;
      o_valid     <= 1'b0;
    end else if (hold) begin
      o_data_alu  <= o_data_alu;
    end else if (i_flush) begin
      o_data_alu  <= '0;
      o_data_mem  <= '0;
      o_wb_select <= 1'b1;
      o_reg_write <= 1'b0;
      o_rd_addr   <= '0;
      o_valid     <= 1'b0;
    end else if (!i_stall) begin
      o_data_alu  <= i_data_alu;
      o_data_mem  <= mem_fmt;
      o_wb_select <= ~i_mem_to_reg;
      // Writes to $zero are dropped here so the register file need not check.
      o_reg_write <= i_reg_write & i_valid & (i_rd_addr != '0);
      o_rd_addr   <= i_rd_addr;
      o_valid     <= i_valid;
    end
  end

`ifdef MEM_WB_HALT_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_halt <= 1'b0;
    end else if (!o_halt && !i_flush && !i_stall && i_valid && i_halt) begin
      o_halt <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_latch.sv
module tb_mem_wb_latch;

  logic        i_clk = 1'b0;
  logic        i_reset, i_stall, i_flush, i_valid;
  logic [31:0] i_data_alu, i_data_mem_raw;
  logic [1:0]  i_addr_low, i_mem_size;
  logic        i_mem_unsigned, i_mem_to_reg, i_reg_write;
  logic [4:0]  i_rd_addr;
  logic [31:0] o_data_alu, o_data_mem;
  logic        o_wb_select, o_reg_write, o_valid;
  logic [4:0]  o_rd_addr;
`ifdef MEM_WB_HALT_EN
  logic        i_halt, o_halt;
  logic        m_halt;
`endif

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [31:0] m_alu, m_mem;
  logic        m_sel, m_rw, m_valid;
  logic [4:0]  m_rd;

  mem_wb_latch #(.NB_INST(32), .NB_ADDR(5)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_stall(i_stall), .i_flush(i_flush),
    .i_valid(i_valid), .i_data_alu(i_data_alu), .i_data_mem_raw(i_data_mem_raw),
    .i_addr_low(i_addr_low), .i_mem_size(i_mem_size),
    .i_mem_unsigned(i_mem_unsigned), .i_mem_to_reg(i_mem_to_reg),
    .i_reg_write(i_reg_write), .i_rd_addr(i_rd_addr),
`ifdef MEM_WB_HALT_EN
    .i_halt(i_halt), .o_halt(o_halt),
`endif
    .o_data_alu(o_data_alu), .o_data_mem(o_data_mem), .o_wb_select(o_wb_select),
    .o_reg_write(o_reg_write), .o_rd_addr(o_rd_addr), .o_valid(o_valid)
  );

  always #5 i_clk = ~i_clk;

  // Load formatting from the rules: shift the addressed lane down, mask, extend.
  function automatic logic [31:0] fmt(input logic [31:0] raw, input logic [1:0] off,
                                      input logic [1:0] size, input logic uns);
    logic [31:0] v;
    if (size == 2'b00) begin
      v = (raw >> (8 * int'(off))) & 32'h0000_00FF;
      if (!uns && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else if (size == 2'b01) begin
      v = (raw >> (off[1] ? 16 : 0)) & 32'h0000_FFFF;
      if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else begin
      v = raw;
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bubble_model();
    m_alu = 0; m_mem = 0; m_sel = 1; m_rw = 0; m_rd = 0; m_valid = 0;
  endtask

  task automatic model_edge();
    logic frozen;
    frozen = 1'b0;
`ifdef MEM_WB_HALT_EN
    frozen = m_halt;
`endif
    if (i_reset) begin
      bubble_model();
`ifdef MEM_WB_HALT_EN
      m_halt = 0;
`endif
    end else if (frozen) begin
      // nothing moves
    end else if (i_flush) begin
      bubble_model();
    end else if (!i_stall) begin
      m_alu   = i_data_alu;
      m_mem   = fmt(i_data_mem_raw, i_addr_low, i_mem_size, i_mem_unsigned);
      m_sel   = !i_mem_to_reg;
      m_rw    = i_reg_write && i_valid && (i_rd_addr != 0);
      m_rd    = i_rd_addr;
      m_valid = i_valid;
`ifdef MEM_WB_HALT_EN
      if (i_valid && i_halt) m_halt = 1;
`endif
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".alu"},   o_data_alu, m_alu);
    if (!m_sel) chk({tag, ".mem"}, o_data_mem, m_mem);
    else if (!m_valid) chk({tag, ".mem"}, o_data_mem, m_mem);
    chk({tag, ".sel"},   {31'd0, o_wb_select}, {31'd0, m_sel});
    chk({tag, ".rw"},    {31'd0, o_reg_write}, {31'd0, m_rw});
    chk({tag, ".rd"},    {27'd0, o_rd_addr},   {27'd0, m_rd});
    chk({tag, ".valid"}, {31'd0, o_valid},     {31'd0, m_valid});
`ifdef MEM_WB_HALT_EN
    chk({tag, ".halt"},  {31'd0, o_halt},      {31'd0, m_halt});
`endif
  endtask

  task automatic rand_fields();
    i_valid        = 1'($urandom);
    i_data_alu     = $urandom;
    i_data_mem_raw = $urandom;
    i_addr_low     = 2'($urandom);
    i_mem_size     = 2'($urandom);
    i_mem_unsigned = 1'($urandom);
    i_mem_to_reg   = 1'($urandom);
    i_reg_write    = 1'($urandom);
    i_rd_addr      = 5'($urandom);
`ifdef MEM_WB_HALT_EN
    i_halt         = 1'b0;
`endif
  endtask

  // Apply current inputs over one rising edge and check just after it.
  task automatic tick(input string tag);
    @(posedge i_clk);
    model_edge();
    #1;
    check_all(tag);
    @(negedge i_clk);
  endtask

  task automatic ctl(input logic rst, input logic stl, input logic fl);
    i_reset = rst; i_stall = stl; i_flush = fl;
  endtask

  task automatic load_fmt(input logic [31:0] raw, input logic [1:0] off,
                          input logic [1:0] size, input logic uns);
    rand_fields();
    ctl(0, 0, 0);
    i_valid = 1; i_mem_to_reg = 1;
    i_data_mem_raw = raw; i_addr_low = off; i_mem_size = size; i_mem_unsigned = uns;
  endtask

  logic [31:0] lb_exp [4];

  initial begin
    bubble_model();
`ifdef MEM_WB_HALT_EN
    m_halt = 0;
`endif
    rand_fields();
    ctl(1, 1'($urandom), 1'($urandom));
    @(negedge i_clk);
    tick("reset0");
    rand_fields();
    tick("reset1");
    chk("reset.alu_lit", o_data_alu, 32'h0);
    chk("reset.mem_lit", o_data_mem, 32'h0);
    chk("reset.sel_lit", {31'd0, o_wb_select}, 32'd1);

    // Byte loads, signed, every offset
    lb_exp[0] = 32'h0000_0001; lb_exp[1] = 32'h0000_007F;
    lb_exp[2] = 32'hFFFF_FFFF; lb_exp[3] = 32'hFFFF_FF80;
    for (int k = 0; k < 4; k++) begin
      load_fmt(32'h80FF_7F01, 2'(k), 2'b00, 1'b0);
      tick("lb");
      chk("lb_lit", o_data_mem, lb_exp[k]);
    end
    load_fmt(32'h80FF_7F01, 2'd2, 2'b00, 1'b1);
    tick("lbu");
    chk("lbu_lit", o_data_mem, 32'h0000_00FF);

    load_fmt(32'h8001_F00F, 2'b00, 2'b01, 1'b0);
    tick("lh");
    chk("lh_lit", o_data_mem, 32'hFFFF_F00F);
    load_fmt(32'h8001_F00F, 2'b10, 2'b01, 1'b1);
    tick("lhu");
    chk("lhu_lit", o_data_mem, 32'h0000_8001);
    load_fmt(32'h8001_F00F, 2'b11, 2'b10, 1'b0);
    tick("lw");
    chk("lw_lit", o_data_mem, 32'h8001_F00F);
    load_fmt(32'h8001_F00F, 2'b01, 2'b11, 1'b0);
    tick("lw11");
    chk("lw11_lit", o_data_mem, 32'h8001_F00F);

    // Stall holds, then flush beats stall
    rand_fields();
    ctl(0, 0, 0);
    i_valid = 1; i_reg_write = 1; i_rd_addr = 5'd5;
    tick("load_rd5");
    for (int k = 0; k < 3; k++) begin
      rand_fields();
      ctl(0, 1, 0);
      tick("stall");
      chk("stall.rd_lit", {27'd0, o_rd_addr}, 32'd5);
      chk("stall.rw_lit", {31'd0, o_reg_write}, 32'd1);
    end
    rand_fields();
    ctl(0, 1, 1);
    tick("stall_flush");
    chk("flush.valid_lit", {31'd0, o_valid}, 32'd0);
    chk("flush.rw_lit", {31'd0, o_reg_write}, 32'd0);

    // $zero and invalid
    rand_fields();
    ctl(0, 0, 0);
    i_valid = 1; i_reg_write = 1; i_rd_addr = 5'd0;
    tick("rd_zero");
    chk("zero.rw_lit", {31'd0, o_reg_write}, 32'd0);
    chk("zero.valid_lit", {31'd0, o_valid}, 32'd1);
    rand_fields();
    ctl(0, 0, 0);
    i_valid = 0; i_reg_write = 1; i_rd_addr = 5'd7;
    tick("invalid");
    chk("invalid.rw_lit", {31'd0, o_reg_write}, 32'd0);

    // Reset mid-stall, then normal load on the next edge
    rand_fields();
    ctl(0, 0, 0);
    i_valid = 1; i_reg_write = 1; i_rd_addr = 5'd9;
    tick("pre_rst");
    rand_fields();
    ctl(1, 1, 0);
    tick("rst_in_stall");
    rand_fields();
    ctl(0, 0, 0);
    i_valid = 1; i_reg_write = 1; i_rd_addr = 5'd12;
    tick("post_rst");
    chk("post_rst.rd_lit", {27'd0, o_rd_addr}, 32'd12);

`ifdef MEM_WB_HALT_EN
    rand_fields();
    ctl(0, 0, 0);
    i_valid = 1; i_halt = 1;
    tick("halt_cap");
    chk("halt.set_lit", {31'd0, o_halt}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      rand_fields();
      ctl(0, 0, k == 1);
      tick("halted");
    end
    rand_fields();
    ctl(1, 0, 0);
    tick("halt_rst");
    chk("halt.clr_lit", {31'd0, o_halt}, 32'd0);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rand_fields();
      ctl(($urandom % 32) == 0, ($urandom % 4) == 0, ($urandom % 8) == 0);
`ifdef MEM_WB_HALT_EN
      i_halt = ($urandom % 64) == 0;
`endif
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
